// File: rtl/display_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : display_capture
// Description : Receive-side monitor for an 8-digit multiplexed seven-segment
//               display bus. Registers the scanned Anode/Cathode lines and
//               waits for each digit slot to hold steady. Once a slot is
//               stable it decodes the cathode pattern to a hex nibble and a
//               decimal point. When all eight slots have been captured it
//               publishes one coherent frame.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SETTLE      consecutive identical samples needed to accept a slot (1..15)
//   TO_W        stall counter width; stall after 2^TO_W-1 idle cycles
// Ports
//   clock       system clock, same domain as the display driver
//   reset       synchronous, active-low reset
//   Anode[7:0]  digit enables, active low, bit i = digit i
//   Cathode[7:0] segments, active low, [7:1] = a..g, [0] = dp
//   digits[31:0] published frame, nibble i = digit i
//   dps[7:0]    published decimal points, active high
//   seg_ok[7:0] bit i set when digit i matched the hex table
//   frame_done  one-cycle pulse when digits/dps/seg_ok update
//   ghost_err   sticky, a settled Anode had more than one low bit
//   stall       no digit accepted for 2^TO_W-1 cycles
// ============================================================================
module display_capture #(
    parameter int unsigned SETTLE = 4,
    parameter int unsigned TO_W   = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  Anode,
    input  logic [7:0]  Cathode,
    output logic [31:0] digits,
    output logic [7:0]  dps,
    output logic [7:0]  seg_ok,
    output logic        frame_done,
    output logic        ghost_err,
    output logic        stall
);

    localparam logic [4:0]      c_settle = 5'(SETTLE);
    localparam logic [7:0]      c_idle   = 8'hFF;
    localparam logic [TO_W-1:0] c_one    = {{(TO_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_WAIT     = 2'd0,
        ST_SETTLING = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input stage: current sample (s) and the one before it (p)
    // ------------------------------------------------------------------
    logic [7:0] r_s_an;
    logic [7:0] r_s_ca;
    logic [7:0] r_p_an;
    logic [7:0] r_p_ca;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_s_an <= c_idle;
            r_s_ca <= 8'hFF;
            r_p_an <= c_idle;
            r_p_ca <= 8'hFF;
        end else begin
            r_s_an <= Anode;
            r_s_ca <= Cathode;
            r_p_an <= r_s_an;
            r_p_ca <= r_s_ca;
        end
    end

    logic w_idle;
    logic w_changed;

    assign w_idle    = (r_s_an == c_idle);
    assign w_changed = ({r_s_an, r_s_ca} != {r_p_an, r_p_ca});

    // ------------------------------------------------------------------
    // Settle FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [4:0] w_cnt_inc;
    logic       w_accept;

    assign w_cnt_inc = {1'b0, r_cnt} + 5'd1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_WAIT;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A fresh sample counts as the first of a run (cnt=1). With SETTLE=1
    // that first sample is already enough, so it is accepted straight away.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (!w_idle) begin
                    w_cnt_nxt = 4'd1;
                    if (c_settle <= 5'd1) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_HELD;
                    end else begin
                        w_state_nxt = ST_SETTLING;
                    end
                end
            end
            ST_SETTLING: begin
                if (w_idle) begin
                    w_state_nxt = ST_WAIT;
                end else if (w_changed) begin
                    w_cnt_nxt = 4'd1;
                    if (c_settle <= 5'd1) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_HELD;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc[3:0];
                    if (w_cnt_inc >= c_settle) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                // A steady sample is never accepted twice; only a change
                // re-arms the settle sequence.
                if (w_changed) begin
                    if (w_idle) begin
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_cnt_nxt = 4'd1;
                        if (c_settle <= 5'd1) begin
                            w_accept = 1'b1;
                        end else begin
                            w_state_nxt = ST_SETTLING;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Digit select classification
    // ------------------------------------------------------------------
    logic [7:0] w_low;
    logic       w_multi;
    logic       w_single;
    logic       w_acc_one;
    logic       w_acc_ghost;
    logic [7:0] w_acc_mask;

    // Clearing the lowest set bit leaves something only if two or more
    // digit enables are active at once.
    assign w_low       = ~r_s_an;
    assign w_multi     = |(w_low & (w_low - 8'd1));
    assign w_single    = (w_low != 8'h00) && !w_multi;
    assign w_acc_one   = w_accept && w_single;
    assign w_acc_ghost = w_accept && w_multi;
    assign w_acc_mask  = w_acc_one ? w_low : 8'h00;

    // ------------------------------------------------------------------
    // Segment decode, active-low a..g
    // ------------------------------------------------------------------
    logic [3:0] w_dec_nib;
    logic       w_dec_ok;

    always_comb begin
        w_dec_nib = 4'h0;
        w_dec_ok  = 1'b1;
        case (r_s_ca[7:1])
            7'h01:   w_dec_nib = 4'h0;
            7'h4F:   w_dec_nib = 4'h1;
            7'h12:   w_dec_nib = 4'h2;
            7'h06:   w_dec_nib = 4'h3;
            7'h4C:   w_dec_nib = 4'h4;
            7'h24:   w_dec_nib = 4'h5;
            7'h20:   w_dec_nib = 4'h6;
            7'h0F:   w_dec_nib = 4'h7;
            7'h00:   w_dec_nib = 4'h8;
            7'h04:   w_dec_nib = 4'h9;
            7'h08:   w_dec_nib = 4'hA;
            7'h60:   w_dec_nib = 4'hB;
            7'h31:   w_dec_nib = 4'hC;
            7'h42:   w_dec_nib = 4'hD;
            7'h30:   w_dec_nib = 4'hE;
            7'h38:   w_dec_nib = 4'hF;
            default: w_dec_ok  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow buffer: one slot per digit, last accepted value wins
    // ------------------------------------------------------------------
    logic [31:0] w_sh_dig;
    logic [7:0]  w_sh_dp;
    logic [7:0]  w_sh_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            logic [3:0] r_nib;
            logic       r_dp;
            logic       r_ok;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    r_nib <= 4'h0;
                    r_dp  <= 1'b0;
                    r_ok  <= 1'b0;
                end else if (w_acc_mask[gi]) begin
                    r_nib <= w_dec_nib;
                    r_dp  <= ~r_s_ca[0];
                    r_ok  <= w_dec_ok;
                end
            end

            assign w_sh_dig[gi*4 +: 4] = r_nib;
            assign w_sh_dp[gi]         = r_dp;
            assign w_sh_ok[gi]         = r_ok;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame publish, ghost flag and stall watchdog
    // ------------------------------------------------------------------
    logic [7:0]      r_seen;
    logic [TO_W-1:0] r_stall_cnt;
    logic            w_publish;
    logic            w_stall_max;

    assign w_publish   = (r_seen == 8'hFF);
    assign w_stall_max = &r_stall_cnt;
    assign stall       = w_stall_max;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_seen      <= 8'h00;
            r_stall_cnt <= '0;
            digits      <= 32'h0;
            dps         <= 8'h00;
            seg_ok      <= 8'h00;
            frame_done  <= 1'b0;
            ghost_err   <= 1'b0;
        end else begin
            frame_done <= w_publish;
            if (w_publish) begin
                digits <= w_sh_dig;
                dps    <= w_sh_dp;
                seg_ok <= w_sh_ok;
            end
            // The publish reads the shadow as it stood before this cycle,
            // so an accept landing in the same cycle starts the next frame.
            r_seen <= (w_publish ? 8'h00 : r_seen) | w_acc_mask;
            if (w_acc_ghost) begin
                ghost_err <= 1'b1;
            end
            if (w_acc_one) begin
                r_stall_cnt <= '0;
            end else if (!w_stall_max) begin
                r_stall_cnt <= r_stall_cnt + c_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_display_capture
// Description : Self-checking bench for display_capture. A sample-history
//               reference model is compared against every output after every
//               clock edge. On top of that come directed sequences, a
//               decode vector table and a randomized scan phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_capture;

    localparam int SETTLE    = 4;
    localparam int TO_W      = 6;
    localparam int STALL_MAX = (1 << TO_W) - 1;

    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic [7:0]  Anode   = 8'hFF;
    logic [7:0]  Cathode = 8'hFF;
    logic [31:0] digits;
    logic [7:0]  dps;
    logic [7:0]  seg_ok;
    logic        frame_done;
    logic        ghost_err;
    logic        stall;

    display_capture #(
        .SETTLE (SETTLE),
        .TO_W   (TO_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .Anode      (Anode),
        .Cathode    (Cathode),
        .digits     (digits),
        .dps        (dps),
        .seg_ok     (seg_ok),
        .frame_done (frame_done),
        .ghost_err  (ghost_err),
        .stall      (stall)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int errors   = 0;
    int fd_count = 0;

    // ---------------- reference model state ----------------
    logic [7:0]  m_s_an;
    logic [7:0]  m_s_ca;
    int          m_run;      // length of the current run of identical samples
    logic [7:0]  m_seen;
    logic [3:0]  m_nib [8];
    logic        m_dp  [8];
    logic        m_ok  [8];
    logic [31:0] m_digits;
    logic [7:0]  m_dps;
    logic [7:0]  m_oks;
    logic        m_fd;
    logic        m_ghost;
    int          m_stall;

    function automatic logic [6:0] hex_seg(input int v);
        case (v)
            0: return 7'h01;  1: return 7'h4F;  2: return 7'h12;  3: return 7'h06;
            4: return 7'h4C;  5: return 7'h24;  6: return 7'h20;  7: return 7'h0F;
            8: return 7'h00;  9: return 7'h04; 10: return 7'h08; 11: return 7'h60;
           12: return 7'h31; 13: return 7'h42; 14: return 7'h30; default: return 7'h38;
        endcase
    endfunction

    function automatic logic [7:0] onehot_low(input int d);
        logic [7:0] m;
        m = 8'h01 << d;
        return ~m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_s_an   = 8'hFF;
        m_s_ca   = 8'hFF;
        m_run    = 0;
        m_seen   = 8'h00;
        m_digits = 32'h0;
        m_dps    = 8'h00;
        m_oks    = 8'h00;
        m_fd     = 1'b0;
        m_ghost  = 1'b0;
        m_stall  = 0;
        for (int i = 0; i < 8; i++) begin
            m_nib[i] = 4'h0;
            m_dp[i]  = 1'b0;
            m_ok[i]  = 1'b0;
        end
    endtask

    // One clock edge of the specified behaviour. A slot is accepted on the
    // edge after its sample run reaches exactly SETTLE long.
    task automatic model_edge(input logic [7:0] a, input logic [7:0] c, input logic rn);
        logic       acc;
        logic       pub;
        int         nlow;
        int         idx;
        logic [3:0] nib;
        logic       ok;
        if (!rn) begin
            model_clear();
            return;
        end
        acc  = (m_run == SETTLE) && (m_s_an != 8'hFF);
        nlow = $countones(~m_s_an);
        pub  = (m_seen == 8'hFF);
        m_fd = pub;
        if (pub) begin
            for (int i = 0; i < 8; i++) begin
                m_digits[i*4 +: 4] = m_nib[i];
                m_dps[i]           = m_dp[i];
                m_oks[i]           = m_ok[i];
            end
            m_seen = 8'h00;
        end
        if (acc && nlow == 1) begin
            idx = 0;
            for (int i = 0; i < 8; i++) if (!m_s_an[i]) idx = i;
            nib = 4'h0;
            ok  = 1'b0;
            for (int v = 0; v < 16; v++) begin
                if (hex_seg(v) == m_s_ca[7:1]) begin
                    nib = v[3:0];
                    ok  = 1'b1;
                end
            end
            m_nib[idx]  = nib;
            m_dp[idx]   = ~m_s_ca[0];
            m_ok[idx]   = ok;
            m_seen[idx] = 1'b1;
            m_stall     = 0;
        end else if (m_stall < STALL_MAX) begin
            m_stall++;
        end
        if (acc && nlow > 1) m_ghost = 1'b1;
        if (a == m_s_an && c == m_s_ca) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_s_an = a;
        m_s_ca = c;
    endtask

    task automatic step();
        logic [7:0] a;
        logic [7:0] c;
        logic       r;
        a = Anode;
        c = Cathode;
        r = reset;
        @(posedge clock);
        model_edge(a, c, r);
        #1;
        chk("digits",     digits,     m_digits);
        chk("dps",        dps,        m_dps);
        chk("seg_ok",     seg_ok,     m_oks);
        chk("frame_done", frame_done, m_fd);
        chk("ghost_err",  ghost_err,  m_ghost);
        chk("stall",      stall,      (m_stall == STALL_MAX));
        if (frame_done) fd_count++;
    endtask

    task automatic drive(input logic [7:0] an, input logic [7:0] ca, input int n);
        Anode   = an;
        Cathode = ca;
        repeat (n) step();
    endtask

    task automatic scan(input logic [63:0] cas, input int hold);
        for (int d = 0; d < 8; d++) drive(onehot_low(d), cas[d*8 +: 8], hold);
    endtask

    typedef struct {
        logic [7:0] ca;
        logic [3:0] nib;
        logic       ok;
        logic       dp;
    } vec_t;

    vec_t vecs [22];

    // Digits 0..7 showing 1..8, decimal point on digit 3 only
    localparam logic [63:0] c_t1 = {8'h01, 8'h1F, 8'h41, 8'h49, 8'h98, 8'h0D, 8'h25, 8'h9F};

    initial begin
        int fd0;
        logic [63:0] cas;

        vecs[0]  = '{8'h03, 4'h0, 1'b1, 1'b0};
        vecs[1]  = '{8'h9F, 4'h1, 1'b1, 1'b0};
        vecs[2]  = '{8'h25, 4'h2, 1'b1, 1'b0};
        vecs[3]  = '{8'h0D, 4'h3, 1'b1, 1'b0};
        vecs[4]  = '{8'h99, 4'h4, 1'b1, 1'b0};
        vecs[5]  = '{8'h49, 4'h5, 1'b1, 1'b0};
        vecs[6]  = '{8'h41, 4'h6, 1'b1, 1'b0};
        vecs[7]  = '{8'h1F, 4'h7, 1'b1, 1'b0};
        vecs[8]  = '{8'h01, 4'h8, 1'b1, 1'b0};
        vecs[9]  = '{8'h09, 4'h9, 1'b1, 1'b0};
        vecs[10] = '{8'h11, 4'hA, 1'b1, 1'b0};
        vecs[11] = '{8'hC1, 4'hB, 1'b1, 1'b0};
        vecs[12] = '{8'h63, 4'hC, 1'b1, 1'b0};
        vecs[13] = '{8'h85, 4'hD, 1'b1, 1'b0};
        vecs[14] = '{8'h61, 4'hE, 1'b1, 1'b0};
        vecs[15] = '{8'h71, 4'hF, 1'b1, 1'b0};
        vecs[16] = '{8'hFE, 4'h0, 1'b0, 1'b1};
        vecs[17] = '{8'hFF, 4'h0, 1'b0, 1'b0};
        vecs[18] = '{8'h00, 4'h8, 1'b1, 1'b1};
        vecs[19] = '{8'h9E, 4'h1, 1'b1, 1'b1};
        vecs[20] = '{8'h56, 4'h0, 1'b0, 1'b1};
        vecs[21] = '{8'h02, 4'h0, 1'b1, 1'b1};

        model_clear();

        // ---- reset state ----
        reset = 1'b0;
        repeat (3) step();
        chk("rst_digits", digits, 32'h0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_stall", stall, 1'b0);
        reset = 1'b1;
        drive(8'hFF, 8'hFF, 2);

        // ---- clean scan 1..8 with dp on digit 3 ----
        fd0 = fd_count;
        scan(c_t1, 16);
        drive(8'hFF, 8'hFF, 3);
        chk("t1_frames", fd_count - fd0, 1);
        chk("t1_digits", digits, 32'h87654321);
        chk("t1_dps", dps, 8'h08);
        chk("t1_seg_ok", seg_ok, 8'hFF);

        // ---- digit 2 held one sample short of SETTLE ----
        fd0 = fd_count;
        drive(onehot_low(2), 8'h9F, 3);
        drive(onehot_low(3), 8'h9F, 6);
        drive(onehot_low(4), 8'h9F, 6);
        drive(onehot_low(5), 8'h9F, 6);
        drive(onehot_low(6), 8'h9F, 6);
        drive(onehot_low(7), 8'h9F, 6);
        drive(onehot_low(0), 8'h9F, 6);
        drive(onehot_low(1), 8'h9F, 6);
        drive(8'hFF, 8'hFF, 3);
        chk("t2_no_frame", fd_count - fd0, 0);
        drive(onehot_low(2), 8'h25, 6);
        drive(8'hFF, 8'hFF, 3);
        chk("t2_frame", fd_count - fd0, 1);
        chk("t2_digits", digits, 32'h11111211);
        chk("t2_dps", dps, 8'h00);

        // ---- blank segments with dp lit on digit 5 ----
        fd0 = fd_count;
        cas = {8{8'h09}};
        cas[47:40] = 8'hFE;
        scan(cas, 6);
        drive(8'hFF, 8'hFF, 3);
        chk("t3_frame", fd_count - fd0, 1);
        chk("t3_digits", digits, 32'h99099999);
        chk("t3_dps", dps, 8'h20);
        chk("t3_seg_ok", seg_ok, 8'hDF);

        // ---- ghosting anode ----
        chk("t4_ghost_before", ghost_err, 1'b0);
        drive(8'hFC, 8'h25, 10);
        chk("t4_ghost_set", ghost_err, 1'b1);
        fd0 = fd_count;
        scan(c_t1, 6);
        drive(8'hFF, 8'hFF, 3);
        chk("t4_frame", fd_count - fd0, 1);
        chk("t4_digits", digits, 32'h87654321);
        chk("t4_dps", dps, 8'h08);
        chk("t4_ghost_sticky", ghost_err, 1'b1);

        // ---- reset mid-frame discards partial capture ----
        fd0 = fd_count;
        for (int d = 0; d < 5; d++) drive(onehot_low(d), c_t1[d*8 +: 8], 6);
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int d = 5; d < 8; d++) drive(onehot_low(d), c_t1[d*8 +: 8], 6);
        drive(8'hFF, 8'hFF, 3);
        chk("t5_no_frame", fd_count - fd0, 0);
        chk("t5_digits", digits, 32'h0);
        chk("t5_dps", dps, 8'h00);
        chk("t5_seg_ok", seg_ok, 8'h00);
        chk("t5_ghost_cleared", ghost_err, 1'b0);
        scan(c_t1, 6);
        drive(8'hFF, 8'hFF, 3);
        chk("t5_frame", fd_count - fd0, 1);
        chk("t5_digits_after", digits, 32'h87654321);

        // ---- stall watchdog ----
        reset = 1'b0;
        Anode = 8'hFF;
        Cathode = 8'hFF;
        step();
        reset = 1'b1;
        repeat (62) step();
        chk("t6_stall_62", stall, 1'b0);
        step();
        chk("t6_stall_63", stall, 1'b1);
        drive(onehot_low(0), 8'h9F, 4);
        chk("t6_stall_pre_accept", stall, 1'b1);
        step();
        chk("t6_stall_cleared", stall, 1'b0);
        drive(8'hFF, 8'hFF, 3);

        // ---- decode table vectors ----
        for (int k = 0; k < 22; k++) begin
            fd0 = fd_count;
            scan({8{vecs[k].ca}}, 6);
            drive(8'hFF, 8'hFF, 2);
            chk("vec_frame", fd_count - fd0, 1);
            chk("vec_digits", digits, {8{vecs[k].nib}});
            chk("vec_dps", dps, {8{vecs[k].dp}});
            chk("vec_seg_ok", seg_ok, {8{vecs[k].ok}});
        end

        // ---- randomized scanning against the model ----
        for (int it = 0; it < 400; it++) begin
            int r;
            int hold;
            logic [7:0] an;
            logic [7:0] ca;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
            end
            r = $urandom_range(0, 99);
            if (r < 8)
                an = 8'hFF;
            else if (r < 11)
                an = onehot_low($urandom_range(0, 7)) & onehot_low($urandom_range(0, 7));
            else
                an = onehot_low($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                ca = {hex_seg($urandom_range(0, 15)), 1'($urandom_range(0, 1))};
            else
                ca = 8'($urandom);
            hold = $urandom_range(1, 10);
            drive(an, ca, hold);
        end
        drive(8'hFF, 8'hFF, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation still running at %0t, limit 10000000", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
